// File: rtl/computation_seq_engine_if.sv
// Operand/result handshake bundle for computation_seq_engine.
// master = upstream source + result sink side, slave = engine side.
interface computation_seq_engine_if #(
  parameter int unsigned DW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   i_1;
  logic [DW-1:0]   i_2;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] mul_sum;
  logic            carryout;
  logic            div_zero;
  logic            busy;

  modport master (
    output in_valid, i_1, i_2, out_ready,
    input  in_ready, out_valid, mul_sum, carryout, div_zero, busy
  );

  modport slave (
    input  in_valid, i_1, i_2, out_ready,
    output in_ready, out_valid, mul_sum, carryout, div_zero, busy
  );
endinterface

// File: rtl/computation_seq_engine.sv
// Sequential (i_1/i_2)*(i_1+i_2)+(i_1-i_2) engine using a DW-step restoring divider.
// Operands are captured once per transaction; results are registered and held until consumed.
module computation_seq_engine #(
  parameter int unsigned DW = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  computation_seq_engine_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDiv, StCalc, StOut} state_e;

  state_e          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0]   quo_q, quo_d, rem_q, rem_d;
  logic [2*DW-1:0] mul_sum_q, mul_sum_d;
  logic            carry_q, carry_d;
  logic            dz_q, dz_d;

  logic [DW:0]     shifted;
  logic            fits;
  logic [DW-1:0]   sub;
  logic [DW:0]     sum;
  logic [DW:0]     diff;
  logic [2*DW-1:0] prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      mul_sum_q <= '0;
      carry_q   <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      mul_sum_q <= mul_sum_d;
      carry_q   <= carry_d;
      dz_q      <= dz_d;
    end
  end

  // The dividend shifts out of quo_q MSB-first while quotient bits shift in.
  // A zero divisor always "fits", yielding an all-ones quotient naturally.
  always_comb begin
    shifted = {rem_q, quo_q[DW-1]};
    fits    = shifted >= {1'b0, b_q};
    sub     = shifted[DW-1:0] - b_q;
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    prod    = {{DW{1'b0}}, quo_q} * {{(DW-1){1'b0}}, sum};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    mul_sum_d = mul_sum_q;
    carry_d   = carry_q;
    dz_d      = dz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.i_1;
          b_d     = bus.i_2;
          quo_d   = bus.i_1;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        rem_d = fits ? sub : shifted[DW-1:0];
        quo_d = {quo_q[DW-2:0], fits};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(DW - 1)) begin
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        mul_sum_d = prod + {{(DW-1){diff[DW]}}, diff};
        carry_d   = sum[DW];
        dz_d      = (b_q == '0);
        state_d   = StOut;
      end
      StOut: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = rst_n && (state_q == StIdle);
  assign bus.out_valid = (state_q == StOut);
  assign bus.busy      = (state_q != StIdle);
  assign bus.mul_sum   = mul_sum_q;
  assign bus.carryout  = carry_q;
  assign bus.div_zero  = dz_q;

endmodule

// File: tb/tb_computation_seq_engine.sv
// Directed bench for computation_seq_engine: vectors, latency, backpressure and mid-divide reset.
module tb_computation_seq_engine;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  computation_seq_engine_if #(.DW(16)) bus ();

  computation_seq_engine #(.DW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves the bench just after the accept edge (cycle 0).
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      step(1);
      k++;
    end
    check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.i_1      = a;
    bus.i_2      = b;
    step(1);
    bus.in_valid = 1'b0;
    bus.i_1      = 16'h0;
    bus.i_2      = 16'h0;
  endtask

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_ms, input logic exp_c, input logic exp_dz);
    issue(a, b);
    step(16);
    check({tag, "_no_early_valid"}, 32'(bus.out_valid), 32'd0);
    step(1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_mul_sum"}, bus.mul_sum, exp_ms);
    check({tag, "_carryout"}, 32'(bus.carryout), 32'(exp_c));
    check({tag, "_div_zero"}, 32'(bus.div_zero), 32'(exp_dz));
    step(1);
    check({tag, "_valid_dropped"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.i_1       = 16'h0;
    bus.i_2       = 16'h0;
    bus.out_ready = 1'b1;

    step(2);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_mul_sum", bus.mul_sum, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    run_vec("v100_200", 16'd100, 16'd200, 32'hFFFF_FF9C, 1'b0, 1'b0);
    run_vec("vffff", 16'hFFFF, 16'hFFFF, 32'h0001_FFFE, 1'b1, 1'b0);
    run_vec("v1000_7", 16'd1000, 16'd7, 32'h0002_3273, 1'b0, 1'b0);

    // Backpressure: 1234/56 = 22, 22*1290 + 1178 = 29558.
    bus.out_ready = 1'b0;
    issue(16'd1234, 16'd56);
    step(17);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_mul_sum", bus.mul_sum, 32'h0000_7376);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.i_1      = 16'd9;
      bus.i_2      = 16'd3;
      step(1);
      check("bp_hold_mul_sum", bus.mul_sum, 32'h0000_7376);
      check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step(1);
    check("bp_release_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    step(25);
    check("bp_no_ghost_valid", 32'(bus.out_valid), 32'd0);
    check("bp_no_ghost_busy", 32'(bus.busy), 32'd0);

    run_vec("v5_0", 16'd5, 16'd0, 32'h0005_0000, 1'b0, 1'b1);

    // Reset in the middle of the divide.
    issue(16'd1000, 16'd7);
    step(8);
    check("mid_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_mul_sum", bus.mul_sum, 32'd0);
    check("mr_div_zero", 32'(bus.div_zero), 32'd0);
    check("mr_carryout", 32'(bus.carryout), 32'd0);
    check("mr_busy", 32'(bus.busy), 32'd0);
    check("mr_in_ready", 32'(bus.in_ready), 32'd0);
    check("mr_out_valid", 32'(bus.out_valid), 32'd0);
    step(2);
    rst_n = 1'b1;
    #1;
    check("mr_rel_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (bus.out_valid) seen = 1'b1;
    end
    check("mr_no_stale_valid", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
